// File: rtl/rotate_seq.sv
// Sequential {L,AC} ring rotater for the OPR group-1 path: BSW/RAL/RTL/RAR/RTR and
// variable left/right rotates, one bit per clock. Define ROTATE_SEQ_FAST_EN for two bits per clock.
module rotate_seq #(
  parameter int WIDTH = 12,
  parameter int CW    = 4
) (
  input  logic             SYSCLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [CW-1:0]    CNT,
  input  logic [WIDTH-1:0] AI,
  input  logic             LI,
  input  logic             OE,
  output logic [WIDTH-1:0] AO,
  output logic             LO,
  output logic             BUSY,
  output logic             DONE
);

  // The fixed ops need a count of 2, so the counter is never narrower than 2 bits.
  localparam int RW = (CW > 2) ? CW : 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             l_q, l_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [2:0]       op_q, op_d;

  // One single-bit step of the ring {L,A}; BSW swaps the halves of A and keeps L.
  function automatic logic [WIDTH:0] step(input logic [2:0] op, input logic [WIDTH:0] ring);
    logic [WIDTH:0] res;
    res = ring;
    case (op)
      3'b001:                 res = {ring[WIDTH], ring[WIDTH/2-1:0], ring[WIDTH-1:WIDTH/2]};
      3'b010, 3'b011, 3'b110: res = {ring[WIDTH-1:0], ring[WIDTH]};
      3'b100, 3'b101, 3'b111: res = {ring[0], ring[WIDTH:1]};
      default:                res = ring;
    endcase
    return res;
  endfunction

  function automatic logic [RW-1:0] step_count(input logic [2:0] op, input logic [CW-1:0] cnt);
    logic [RW-1:0] n;
    case (op)
      3'b001, 3'b010, 3'b100: n = RW'(1);
      3'b011, 3'b101:         n = RW'(2);
      3'b110, 3'b111:         n = RW'(cnt);
      default:                n = '0;
    endcase
    return n;
  endfunction

  logic [RW-1:0] start_n;
  assign start_n = step_count(OP, CNT);

  always_comb begin
    // NOTE: every target gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    {l_d, a_d}  = {l_q, a_q};
    rem_d       = rem_q;
    op_d        = op_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          {l_d, a_d} = {LI, AI};
          op_d       = OP;
          rem_d      = start_n;
          state_d    = (start_n == '0) ? DONE_S : RUN;
        end
      end
      RUN: begin
`ifdef ROTATE_SEQ_FAST_EN
        if (rem_q >= RW'(2)) begin
          {l_d, a_d} = step(op_q, step(op_q, {l_q, a_q}));
          rem_d      = rem_q - RW'(2);
          if (rem_q == RW'(2)) state_d = DONE_S;
        end else begin
          {l_d, a_d} = step(op_q, {l_q, a_q});
          rem_d      = rem_q - RW'(1);
          state_d    = DONE_S;
        end
`else
        {l_d, a_d} = step(op_q, {l_q, a_q});
        rem_d      = rem_q - RW'(1);
        if (rem_q == RW'(1)) state_d = DONE_S;
`endif
      end
      DONE_S:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      l_q     <= 1'b0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      l_q     <= l_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign AO   = OE ? a_q : {WIDTH{1'bz}};
  assign LO   = l_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == DONE_S);

endmodule
